// File: rtl/seg_scan_reader.sv
// Seven-segment scan receiver. It registers the multiplexed segment bus, waits for each digit
// to stay stable, decodes the 3-bit value and dp, and reports captures, frames and illegal patterns.
module seg_scan_reader #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    err_clr,
    output logic [3*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dps,
    output logic                    cap_valid,
    output logic [2:0]              cap_idx,
    output logic                    cap_err,
    output logic                    frame_done,
    output logic                    err_sticky
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_e;

    function automatic logic one_hot_low(input logic [NUM_DIGITS-1:0] sel);
        logic [NUM_DIGITS-1:0] act;
        act = ~sel;
        return (act != '0) && ((act & (act - NUM_DIGITS'(1))) == '0);
    endfunction

    function automatic logic [2:0] low_index(input logic [NUM_DIGITS-1:0] sel);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sel[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Returns {illegal, value}; anything outside the 0-7 table decodes as 0.
    function automatic logic [3:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   decode = 4'b0_000;
            7'h06:   decode = 4'b0_001;
            7'h5B:   decode = 4'b0_010;
            7'h4F:   decode = 4'b0_011;
            7'h66:   decode = 4'b0_100;
            7'h6D:   decode = 4'b0_101;
            7'h7D:   decode = 4'b0_110;
            7'h07:   decode = 4'b0_111;
            default: decode = 4'b1_000;
        endcase
    endfunction

    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]              cnt_q, cnt_d;
    state_e                  state_q, state_d;
    logic [3*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dps_q, dps_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    cap_valid_q, cap_valid_d;
    logic [2:0]              cap_idx_q, cap_idx_d;
    logic                    cap_err_q, cap_err_d;
    logic                    frame_done_q, frame_done_d;
    logic                    err_sticky_q, err_sticky_d;

    logic                    changed;
    logic                    sel_ok;
    logic                    in_ok;
    logic [3:0]              dec;
    logic [2:0]              idx;
    logic [NUM_DIGITS-1:0]   seen_next;
    logic                    seg_unused;

    assign seg_unused = seg[8];

    // A change is a new sample that differs from the one currently held in the input stage.
    assign changed = {seg[7:0], dig_sel} != {seg_q, sel_q};
    assign sel_ok  = one_hot_low(sel_q);
    assign in_ok   = one_hot_low(dig_sel);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        seg_d = seg[7:0];
        sel_d = dig_sel;
        cnt_d = cnt_q;
        if (changed || !sel_ok) begin
            cnt_d = '0;
        end else if (cnt_q != STABLE) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_ok) state_d = SETTLE;
            SETTLE: begin
                if (cnt_d == STABLE) state_d = CAPTURE;
                else if (!sel_ok)    state_d = IDLE;
            end
            CAPTURE: state_d = HOLD;
            HOLD:    if (cnt_d != STABLE) state_d = in_ok ? SETTLE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        digits_d     = digits_q;
        dps_d        = dps_q;
        seen_d       = seen_q;
        cap_valid_d  = 1'b0;
        cap_idx_d    = cap_idx_q;
        cap_err_d    = 1'b0;
        frame_done_d = 1'b0;
        dec          = decode(seg_q[6:0]);
        idx          = low_index(sel_q);
        seen_next    = seen_q | (NUM_DIGITS'(1) << idx);
        if (state_d == CAPTURE) begin
            cap_valid_d            = 1'b1;
            cap_idx_d              = idx;
            cap_err_d              = dec[3];
            digits_d[3*idx +: 3]   = dec[2:0];
            dps_d[idx]             = seg_q[7];
            if (&seen_next) begin
                frame_done_d = 1'b1;
                seen_d       = '0;
            end else begin
                seen_d       = seen_next;
            end
        end
        err_sticky_d = cap_err_d ? 1'b1 : (err_clr ? 1'b0 : err_sticky_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= '0;
            sel_q        <= '1;
            cnt_q        <= '0;
            state_q      <= IDLE;
            digits_q     <= '0;
            dps_q        <= '0;
            seen_q       <= '0;
            cap_valid_q  <= 1'b0;
            cap_idx_q    <= '0;
            cap_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            digits_q     <= digits_d;
            dps_q        <= dps_d;
            seen_q       <= seen_d;
            cap_valid_q  <= cap_valid_d;
            cap_idx_q    <= cap_idx_d;
            cap_err_q    <= cap_err_d;
            frame_done_q <= frame_done_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign digits     = digits_q;
    assign dps        = dps_q;
    assign cap_valid  = cap_valid_q;
    assign cap_idx    = cap_idx_q;
    assign cap_err    = cap_err_q;
    assign frame_done = frame_done_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Self-checking bench for seg_scan_reader: directed table, hand-written corner sequences and
// randomized scanning compared against a sample-history reference model.
module tb_seg_scan_reader;

    localparam int ND = 8;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [8:0]    seg;
    logic [ND-1:0] dig_sel;
    logic          err_clr;
    logic [3*ND-1:0] digits;
    logic [ND-1:0] dps;
    logic          cap_valid;
    logic [2:0]    cap_idx;
    logic          cap_err;
    logic          frame_done;
    logic          err_sticky;

    seg_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel), .err_clr(err_clr),
        .digits(digits), .dps(dps), .cap_valid(cap_valid), .cap_idx(cap_idx),
        .cap_err(cap_err), .frame_done(frame_done), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a capture happens after an edge when the last SC+1 samples are identical,
    // carry a one-hot-low select, and the sample before that run was different (or absent).
    typedef struct packed { logic [7:0] s; logic [7:0] d; } samp_t;
    samp_t           hist[$];
    logic [6:0]      pat [8];
    logic [3*ND-1:0] m_digits;
    logic [ND-1:0]   m_dps, m_seen;
    logic            m_valid, m_err, m_frame, m_sticky;
    logic [2:0]      m_idx;

    function automatic bit is_sel_ok(input logic [7:0] d);
        return $countones(~d) == 1;
    endfunction

    function automatic void model_clear();
        hist.delete();
        m_digits = '0; m_dps = '0; m_seen = '0;
        m_valid = 0; m_err = 0; m_frame = 0; m_sticky = 0; m_idx = '0;
    endfunction

    function automatic void model_edge(input logic [8:0] sg, input logic [7:0] ds, input logic clr);
        samp_t cur;
        int    n;
        bit    same;
        bit    fresh;
        int    pos;
        int    val;
        cur = '{s: sg[7:0], d: ds};
        hist.push_back(cur);
        if (hist.size() > SC + 2) void'(hist.pop_front());
        n = hist.size();
        m_valid = 0; m_err = 0; m_frame = 0;
        if (n >= SC + 1 && is_sel_ok(ds)) begin
            same = 1;
            for (int j = n - SC - 1; j < n; j++) if (hist[j] != cur) same = 0;
            fresh = (n == SC + 1) || (hist[n - SC - 2] != cur);
            if (same && fresh) begin
                pos = 0;
                for (int i = 0; i < ND; i++) if (!ds[i]) pos = i;
                val = -1;
                for (int v = 0; v < 8; v++) if (pat[v] == sg[6:0]) val = v;
                m_valid = 1;
                m_idx = 3'(pos);
                m_err = (val < 0);
                m_digits[3*pos +: 3] = (val < 0) ? 3'd0 : 3'(val);
                m_dps[pos] = sg[7];
                m_seen[pos] = 1'b1;
                if (&m_seen) begin
                    m_frame = 1;
                    m_seen = '0;
                end
            end
        end
        m_sticky = m_err ? 1'b1 : (clr ? 1'b0 : m_sticky);
    endfunction

    int         cyc = 0;
    int         n_pulse, n_frame, frame_at_pulse, pulse_cyc;
    logic [2:0] last_idx;
    logic       last_err;

    task automatic step(input logic [8:0] sg, input logic [7:0] ds, input logic clr);
        cyc++;
        seg = sg; dig_sel = ds; err_clr = clr;
        @(posedge clk);
        model_edge(sg, ds, clr);
        @(negedge clk);
        check("cap_valid", 32'(cap_valid), 32'(m_valid));
        check("cap_err", 32'(cap_err), 32'(m_err));
        check("frame_done", 32'(frame_done), 32'(m_frame));
        check("digits", 32'(digits), 32'(m_digits));
        check("dps", 32'(dps), 32'(m_dps));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
        if (m_valid) check("cap_idx", 32'(cap_idx), 32'(m_idx));
        if (cap_valid) begin
            n_pulse++; last_idx = cap_idx; last_err = cap_err; pulse_cyc = cyc;
        end
        if (frame_done) begin
            n_frame++; frame_at_pulse = n_pulse;
        end
    endtask

    task automatic clear_counts();
        n_pulse = 0; n_frame = 0; frame_at_pulse = 0; pulse_cyc = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'h0);
        check({tag, "_dps"}, 32'(dps), 32'h0);
        check({tag, "_pulses"}, {29'h0, cap_valid, cap_err, frame_done}, 32'h0);
        check({tag, "_idx"}, 32'(cap_idx), 32'h0);
        check({tag, "_sticky"}, 32'(err_sticky), 32'h0);
    endtask

    task automatic apply_reset(input int hold);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_reset_outputs("rst_async");
        repeat (hold) begin
            @(negedge clk);
            seg = 9'($urandom);
            dig_sel = 8'($urandom);
            err_clr = 1'($urandom);
            check_reset_outputs("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        err_clr = 1'b0;
    endtask

    typedef struct {
        logic [8:0] seg;
        logic [7:0] sel;
        logic [2:0] exp_val;
        logic       exp_dp;
        logic       exp_err;
        logic [2:0] exp_idx;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int         c0;
        logic [8:0] rs;
        logic [7:0] rd;
        int         len;

        pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
        tbl[0] = '{9'h03F, ~8'h01, 3'd0, 1'b0, 1'b0, 3'd0};
        tbl[1] = '{9'h086, ~8'h02, 3'd1, 1'b1, 1'b0, 3'd1};
        tbl[2] = '{9'h15B, ~8'h04, 3'd2, 1'b0, 1'b0, 3'd2};
        tbl[3] = '{9'h0CF, ~8'h08, 3'd3, 1'b1, 1'b0, 3'd3};
        tbl[4] = '{9'h066, ~8'h10, 3'd4, 1'b0, 1'b0, 3'd4};
        tbl[5] = '{9'h1ED, ~8'h20, 3'd5, 1'b1, 1'b0, 3'd5};
        tbl[6] = '{9'h07D, ~8'h40, 3'd6, 1'b0, 1'b0, 3'd6};
        tbl[7] = '{9'h087, ~8'h80, 3'd7, 1'b1, 1'b0, 3'd7};
        tbl[8] = '{9'h07F, ~8'h01, 3'd0, 1'b0, 1'b1, 3'd0};
        tbl[9] = '{9'h000, ~8'h80, 3'd0, 1'b0, 1'b1, 3'd7};

        seg = 9'($urandom); dig_sel = 8'($urandom); err_clr = 1'b0;
        model_clear();
        apply_reset(3);

        // Blanked bus after release: nothing may pulse.
        clear_counts();
        repeat (20) step(9'($urandom), 8'hFF, 1'b0);
        check("blank_no_pulse", 32'(n_pulse), 32'd0);

        // Single capture with exact latency.
        clear_counts();
        c0 = cyc + 1;
        repeat (10) step(9'h05B, ~8'h04, 1'b0);
        check("single_count", 32'(n_pulse), 32'd1);
        check("single_idx", 32'(last_idx), 32'd2);
        check("single_when", 32'(pulse_cyc), 32'(c0 + SC));
        check("single_val", 32'(digits[8:6]), 32'd2);
        check("single_dp", 32'(dps[2]), 32'd0);

        // Ghost rejection: a short dwell of 4 is never captured.
        clear_counts();
        repeat (3) step(9'h066, ~8'h08, 1'b0);
        c0 = cyc + 1;
        repeat (8) step(9'h007, ~8'h08, 1'b0);
        check("ghost_count", 32'(n_pulse), 32'd1);
        check("ghost_when", 32'(pulse_cyc), 32'(c0 + SC));
        check("ghost_val", 32'(digits[11:9]), 32'd7);

        // Illegal pattern, then sticky clear.
        clear_counts();
        repeat (8) step(9'h1FF, ~8'h20, 1'b0);
        check("illegal_count", 32'(n_pulse), 32'd1);
        check("illegal_err", 32'(last_err), 32'd1);
        check("illegal_val", 32'(digits[17:15]), 32'd0);
        check("illegal_dp", 32'(dps[5]), 32'd1);
        check("illegal_sticky", 32'(err_sticky), 32'd1);
        step(9'h1FF, ~8'h20, 1'b1);
        check("sticky_cleared", 32'(err_sticky), 32'd0);

        // Decode table.
        for (int t = 0; t < 10; t++) begin
            step(9'h000, 8'hFF, 1'b0);
            clear_counts();
            repeat (SC + 3) step(tbl[t].seg, tbl[t].sel, 1'b0);
            check("tbl_count", 32'(n_pulse), 32'd1);
            check("tbl_idx", 32'(last_idx), 32'(tbl[t].exp_idx));
            check("tbl_err", 32'(last_err), 32'(tbl[t].exp_err));
            check("tbl_val", 32'(digits[3*tbl[t].exp_idx +: 3]), 32'(tbl[t].exp_val));
            check("tbl_dp", 32'(dps[tbl[t].exp_idx]), 32'(tbl[t].exp_dp));
        end

        // Full frame: digit i shows 7-i.
        apply_reset(1);
        clear_counts();
        for (int i = 0; i < ND; i++) begin
            repeat (6) step({2'b00, pat[7 - i]}, ~(8'h01 << i), 1'b0);
            step(9'h000, 8'hFF, 1'b0);
        end
        check("frame_pulses", 32'(n_pulse), 32'd8);
        check("frame_done_cnt", 32'(n_frame), 32'd1);
        check("frame_at_8th", 32'(frame_at_pulse), 32'd8);
        check("frame_digits", 32'(digits), 32'h053977);

        // Invalid selects never capture.
        clear_counts();
        repeat (10) step(9'h03F, 8'hF0, 1'b0);
        repeat (10) step(9'h03F, 8'h00, 1'b0);
        check("badsel_no_pulse", 32'(n_pulse), 32'd0);

        // Reset in the 3rd stable cycle of a dwell.
        clear_counts();
        repeat (3) step(9'h04F, ~8'h02, 1'b0);
        #2;
        apply_reset(2);
        check("midrst_no_pulse", 32'(n_pulse), 32'd0);
        c0 = cyc + 1;
        repeat (SC + 3) step(9'h04F, ~8'h02, 1'b0);
        check("midrst_count", 32'(n_pulse), 32'd1);
        check("midrst_when", 32'(pulse_cyc), 32'(c0 + SC));

        // Randomized scanning against the model.
        for (int n = 0; n < 300; n++) begin
            rd = ~(8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) rd = 8'($urandom);
            if ($urandom_range(0, 5) == 0) rs = 9'($urandom);
            else rs = {1'($urandom), 1'($urandom), pat[$urandom_range(0, 7)]};
            len = $urandom_range(1, 9);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 15) == 0) step(9'($urandom), rd, 1'b0);
                else step(rs ^ {1'($urandom), 8'h00}, rd, $urandom_range(0, 15) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_reader.md
# seg_scan_reader

Receive-side counterpart of the team's 3-bit seven-segment decoder. Monitors a multiplexed seven-segment bus (segment pattern plus active-low digit select) and recovers the 3-bit value and decimal point shown on each digit, with a stability filter against scan ghosting. Assembles complete frames of captured digits and flags patterns that do not encode 0–7. Used for self-check loops and for reading display-scan outputs back into logic.

## Interface
- NUM_DIGITS, 8, number of scanned digit positions; legal range 1–8.
- STABLE_CYCLES, 4, consecutive identical samples required before capture; legal range 2–255.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- seg  in  9  segment bus, active high.
  - bit0–bit6 = segments a–g.
  - bit7 = dp.
  - bit8 is ignored.
- dig_sel  in  NUM_DIGITS  digit select, active low, one-hot-low when valid.
- err_clr  in  1  synchronous clear of err_sticky.
- digits  out  3*NUM_DIGITS  last captured value per digit; digit i occupies bits [3i+2:3i].
- dps  out  NUM_DIGITS  last captured dp per digit.
- cap_valid  out  1  one-cycle pulse on each capture.
- cap_idx  out  3  index of the digit captured; valid only with cap_valid.
- cap_err  out  1  one-cycle pulse, coincident with cap_valid, when the pattern was illegal.
- frame_done  out  1  one-cycle pulse when every digit has been captured since the last frame_done.
- err_sticky  out  1  set by any cap_err; cleared only by err_clr or reset.

## Operation
- Decode table, on seg[6:0]:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7.
  - Any other value is illegal: value 0 is stored and cap_err pulses.
  - The dp bit is stored unchanged.
- Input stage: seg and dig_sel are registered once into seg_q and sel_q. All later logic uses the registered copies.
- Stability counter (8 bits):
  - Reset to 0 whenever {seg_q, sel_q} differs from the previous registered sample.
  - Held at 0 while sel_q is not exactly one-hot-low. This covers all-ones (blanking), all-zeros, and multiple low bits.
  - Otherwise increments and saturates at STABLE_CYCLES.
- States:
  - IDLE: no valid select. Go to SETTLE when sel_q becomes one-hot-low.
  - SETTLE: counting. When the count reaches STABLE_CYCLES, go to CAPTURE.
  - CAPTURE: lasts exactly one cycle. Writes digits[idx] and dps[idx], sets seen[idx], pulses cap_valid, then moves to HOLD.
  - HOLD: no recapture while the inputs remain unchanged. On any change, go to SETTLE if the new select is valid, else IDLE.
- Frame tracking:
  - seen is a NUM_DIGITS-bit mask.
  - When a capture makes seen all ones, frame_done pulses in the same cycle as that cap_valid, and seen clears to 0 on the same edge.
  - Re-capturing an already-seen digit overwrites its value and does not double-count.
- Illegal select index (index ≥ NUM_DIGITS): the select is treated as not one-hot and is ignored.
- err_sticky:
  - A cap_err sets it.
  - err_clr clears it.
  - If err_clr and cap_err coincide, the set wins.

## Timing
- Reset values:
  - digits = 0, dps = 0, seen = 0.
  - cap_valid, cap_err and frame_done = 0.
  - cap_idx = 0, err_sticky = 0, counter = 0, state = IDLE.
- Latency: a new valid {seg, dig_sel} is present at edge k and held.
  - It is registered at edge k.
  - cap_valid, cap_idx and cap_err are asserted during the cycle after edge k+STABLE_CYCLES.
  - digits and dps reflect the new value from that same cycle onward.
- A glitch of one cycle or more inside the window restarts the count, so the earliest capture moves to STABLE_CYCLES edges after the glitch ends.
- A dwell shorter than STABLE_CYCLES samples produces no capture and leaves digits unchanged.
- Reset asserted mid-count or during CAPTURE:
  - Takes effect immediately and asynchronously.
  - No pulse is emitted.
  - After release, capture requires a full STABLE_CYCLES dwell.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 with random inputs.
  - Required: all outputs 0.
  - Release rst_n with dig_sel=all ones → no pulses for 20 cycles.
- Single capture, STABLE_CYCLES=4: seg=0x5B, dig_sel=~8'h04, held 10 cycles.
  - Required: exactly one cap_valid, with cap_idx=2, digits[8:6]=2, dps[2]=0.
  - The pulse appears in the cycle after the 4th edge following the registered change.
- Ghost rejection: seg=0x66 for 3 cycles, then 0x07 held.
  - Required: no capture of 4; a single capture of 7 occurs 4 edges after the switch.
- Illegal pattern: seg=0x1FF on digit 5.
  - Required: cap_err and cap_valid together, digits[17:15]=0, dps[5]=1, err_sticky=1.
  - err_clr then clears err_sticky.
- Full frame: scan digits 0–7 showing values 7..0, 6 cycles per digit, with 1 blanking cycle between digits.
  - Required: 8 cap_valid pulses, frame_done coincident with the 8th, digits=24'h053977 (digit i = 7−i).
- Invalid select and reset mid-dwell:
  - dig_sel=8'hF0 held → no capture.
  - Assert rst_n=0 during the 3rd stable cycle of a valid digit → no pulse, outputs cleared.
